// File: rtl/spi_pkg.sv
// Shared SPI frame definitions, imported by both the initiator and the
// slave-side receive FSM so command encodings and widths cannot drift apart.
package spi_pkg;
  localparam int FRAME_W = 10;  // {cmd[1:0], data[7:0]}
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SHIFT_OUT,
    WAIT_RD,
    SHIFT_IN
  } state_t;
endpackage

// File: rtl/counter_down.sv
// 4-bit loadable down counter used to time the shift/wait phases of a frame.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (has priority over en)
//   load_val  : value to load
//   en        : decrement by one
//   zero      : count currently equals zero
module counter_down
  import spi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: select bit + 10-bit {cmd, data} word out on MOSI, and for
// read-data commands an 8-bit response collected from MISO. SCLK is clk.
//   clk, rst          : system clock, synchronous active-high reset
//   start, cmd, wdata : frame request (accepted only when busy=0)
//   busy              : frame in progress (SS_n low)
//   done              : one-cycle pulse at frame end
//   rdata, rdata_valid: last read byte and its one-cycle strobe (cmd 11)
//   SS_n, MOSI, MISO  : SPI pins
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);
  state_t             state, state_n;
  logic [FRAME_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0]  rx_shreg, rx_n, rdata_n;
  logic               rd_frame, rd_n;
  logic               ss_n_n, mosi_n, done_n, rv_n;
  logic               cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0]   cnt_val;

  counter_down u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      rx_shreg    <= '0;
      rd_frame    <= 1'b0;
      rdata       <= '0;
      SS_n        <= 1'b1;
      MOSI        <= 1'b0;
      done        <= 1'b0;
      rdata_valid <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      rx_shreg    <= rx_n;
      rd_frame    <= rd_n;
      rdata       <= rdata_n;
      SS_n        <= ss_n_n;
      MOSI        <= mosi_n;
      done        <= done_n;
      rdata_valid <= rv_n;
    end
  end

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    rx_n     = rx_shreg;
    rd_n     = rd_frame;
    rdata_n  = rdata;
    ss_n_n   = SS_n;
    mosi_n   = MOSI;
    done_n   = 1'b0;
    rv_n     = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    case (state)
      IDLE: begin
        ss_n_n = 1'b1;
        mosi_n = 1'b0;
        if (start) begin
          shreg_n = {cmd, wdata};
          rd_n    = (cmd == CMD_RD_DATA);
          ss_n_n  = 1'b0;
          mosi_n  = cmd[1];  // select bit: 1 = read
          state_n = SELECT;
        end
      end
      SELECT: begin
        // First word bit leaves here, so SHIFT_OUT sees nine more edges
        // before the count reaches zero on the edge that ends the word.
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(FRAME_W - 1);
        mosi_n   = shreg[FRAME_W-1];
        shreg_n  = {shreg[FRAME_W-2:0], 1'b0};
        state_n  = SHIFT_OUT;
      end
      SHIFT_OUT: begin
        if (cnt_zero) begin
          mosi_n = 1'b0;
          if (rd_frame) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(RD_WAIT - 1);
            state_n  = WAIT_RD;
          end else begin
            ss_n_n  = 1'b1;
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_en  = 1'b1;
          mosi_n  = shreg[FRAME_W-1];
          shreg_n = {shreg[FRAME_W-2:0], 1'b0};
        end
      end
      WAIT_RD: begin
        mosi_n = 1'b0;
        if (cnt_zero) begin
          // The edge that ends the wait already samples MISO bit 7,
          // leaving seven bits for SHIFT_IN.
          rx_n     = {rx_shreg[DATA_W-2:0], MISO};
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(DATA_W - 2);
          state_n  = SHIFT_IN;
        end else begin
          cnt_en = 1'b1;
        end
      end
      SHIFT_IN: begin
        rx_n = {rx_shreg[DATA_W-2:0], MISO};
        if (cnt_zero) begin
          rdata_n = {rx_shreg[DATA_W-2:0], MISO};
          rv_n    = 1'b1;
          done_n  = 1'b1;
          ss_n_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
endmodule
